// File: rtl/switch_display_if.sv
// Board-facing bundle of the switch/display controller: raw switches in,
// debounced LEDs, six active-low digit patterns and the busy flag out.
interface switch_display_if;
    logic [0:5] SW;
    logic [0:5] LEDR;
    logic [0:7] HEX0;
    logic [0:7] HEX1;
    logic [0:7] HEX2;
    logic [0:7] HEX3;
    logic [0:7] HEX4;
    logic [0:7] HEX5;
    logic       BUSY;

    // Board / test side: drives the switches, observes the displays.
    modport master (
        output SW,
        input  LEDR, HEX0, HEX1, HEX2, HEX3, HEX4, HEX5, BUSY
    );

    // Controller side.
    modport slave (
        input  SW,
        output LEDR, HEX0, HEX1, HEX2, HEX3, HEX4, HEX5, BUSY
    );
endinterface

// File: rtl/switch_display_controller.sv
// Six-channel switch debouncer feeding six 7-segment digits through one
// shared encoder. A channel whose debounced level flips raises a pending
// request; a round-robin scheduler writes one digit per clock.
module switch_display_controller #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic            CLOCK_50,
    input  logic            RESET,
    switch_display_if.slave io
);
    localparam int NUM_CH = 6;
    localparam int CNT_W  = $clog2(DEBOUNCE_CYCLES);

    localparam logic [CNT_W-1:0] CNT_MAX     = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [2:0]       LAST_CH     = 3'd5;
    // Active-low segments, index 0 = a ... 6 = g, 7 = dp.
    localparam logic [0:7]       GLYPH_ONE   = 8'b10011111;
    localparam logic [0:7]       GLYPH_ZERO  = 8'b00000011;
    localparam logic [0:7]       GLYPH_BLANK = 8'b11111111;

    // The only glyphs this board ever shows.
    function automatic logic [0:7] encode_digit(input logic level);
        return level ? GLYPH_ONE : GLYPH_ZERO;
    endfunction

    // Channel index modulo the channel count.
    function automatic logic [2:0] wrap_ch(input int idx);
        return 3'(idx % NUM_CH);
    endfunction

    logic [0:NUM_CH-1] sync1_q,   sync1_d;
    logic [0:NUM_CH-1] sync2_q,   sync2_d;
    logic [0:NUM_CH-1] stable_q,  stable_d;
    logic [0:NUM_CH-1] pending_q, pending_d;
    logic [CNT_W-1:0]  cnt_q [NUM_CH];
    logic [CNT_W-1:0]  cnt_d [NUM_CH];
    logic [0:7]        hex_q [NUM_CH];
    logic [0:7]        hex_d [NUM_CH];
    logic [2:0]        last_q,    last_d;

    logic [0:NUM_CH-1] flip;
    logic              grant_valid;
    logic [2:0]        grant_idx;

    // Two-flop synchronizer on the asynchronous switch levels.
    always_comb begin
        sync1_d = io.SW;
        sync2_d = sync1_q;
    end

    // Per-channel debounce: flip the stable level after CNT_MAX+1 differing edges.
    always_comb begin
        // NOTE: every output of this block gets a default before any branch, so no path leaves one unassigned and no latch is inferred.
        stable_d = stable_q;
        flip     = '0;
        for (int n = 0; n < NUM_CH; n++) begin
            cnt_d[n] = cnt_q[n];
            if (sync2_q[n] == stable_q[n]) begin
                cnt_d[n] = '0;
            end else if (cnt_q[n] == CNT_MAX) begin
                stable_d[n] = sync2_q[n];
                cnt_d[n]    = '0;
                flip[n]     = 1'b1;
            end else begin
                cnt_d[n] = cnt_q[n] + CNT_W'(1);
            end
        end
    end

    // Round-robin search for the first pending channel after the last grant.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = last_q;
        for (int off = 1; off <= NUM_CH; off++) begin
            if (!grant_valid && pending_q[wrap_ch(int'(last_q) + off)]) begin
                grant_valid = 1'b1;
                grant_idx   = wrap_ch(int'(last_q) + off);
            end
        end
    end

    // Grant bookkeeping and digit write; a fresh flip overrides the clear.
    always_comb begin
        pending_d = pending_q;
        last_d    = last_q;
        hex_d     = hex_q;
        if (grant_valid) begin
            pending_d[grant_idx] = 1'b0;
            last_d               = grant_idx;
            hex_d[grant_idx]     = encode_digit(stable_q[grant_idx]);
        end
        pending_d = pending_d | flip;
    end

    // State registers with synchronous reset that re-arms a full refresh.
    always_ff @(posedge CLOCK_50) begin
        // NOTE: non-blocking assignments so every flop samples pre-edge values regardless of statement order.
        if (RESET) begin
            sync1_q   <= '0;
            sync2_q   <= '0;
            stable_q  <= '0;
            pending_q <= '1;
            last_q    <= LAST_CH;
            for (int n = 0; n < NUM_CH; n++) begin
                cnt_q[n] <= '0;
                // NOTE: the digit register array is reset explicitly; the pins must show blank, not power-up garbage.
                hex_q[n] <= GLYPH_BLANK;
            end
        end else begin
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            stable_q  <= stable_d;
            pending_q <= pending_d;
            last_q    <= last_d;
            for (int n = 0; n < NUM_CH; n++) begin
                cnt_q[n] <= cnt_d[n];
                hex_q[n] <= hex_d[n];
            end
        end
    end

    assign io.LEDR = stable_q;
    assign io.BUSY = |pending_q;
    assign io.HEX0 = hex_q[0];
    assign io.HEX1 = hex_q[1];
    assign io.HEX2 = hex_q[2];
    assign io.HEX3 = hex_q[3];
    assign io.HEX4 = hex_q[4];
    assign io.HEX5 = hex_q[5];
endmodule

// File: tb/tb_switch_display_controller.sv
// Bench for switch_display_controller: two instances (debounce 4 and 2)
// observed through full-output snapshots compared by a timed scoreboard.
module tb_switch_display_controller;
    localparam logic [0:7]  H1 = 8'b10011111;
    localparam logic [0:7]  H0 = 8'b00000011;
    localparam logic [0:7]  HB = 8'b11111111;
    localparam logic [0:47] ALL_BLANK = {6{HB}};
    localparam logic [0:47] ALL_ZERO  = {6{H0}};
    localparam logic [0:47] ALL_ONE   = {6{H1}};

    typedef struct packed {
        logic [0:5]  ledr;
        logic        busy;
        logic [0:47] hex;
    } snap_t;

    typedef struct {
        int    rel;
        snap_t exp;
    } vec_t;

    typedef struct {
        int    at;
        int    dut;
        string name;
        snap_t exp;
    } sb_t;

    logic clk = 1'b0;
    logic rst4;
    logic rst2;
    int   ecount  = 0;
    int   n_checks = 0;
    int   n_pass   = 0;
    sb_t  sb_q[$];

    always #5 clk = ~clk;

    switch_display_if if4 ();
    switch_display_if if2 ();

    switch_display_controller #(.DEBOUNCE_CYCLES(4)) dut4 (
        .CLOCK_50 (clk),
        .RESET    (rst4),
        .io       (if4)
    );

    switch_display_controller #(.DEBOUNCE_CYCLES(2)) dut2 (
        .CLOCK_50 (clk),
        .RESET    (rst2),
        .io       (if2)
    );

    function automatic snap_t mk(input logic [0:5] ledr, input logic busy, input logic [0:47] hex);
        snap_t s;
        s.ledr = ledr;
        s.busy = busy;
        s.hex  = hex;
        return s;
    endfunction

    function automatic snap_t with_hex(input snap_t s, input int ch, input logic [0:7] v);
        s.hex[ch*8 +: 8] = v;
        return s;
    endfunction

    function automatic snap_t snap(input int which);
        if (which == 4)
            return mk(if4.LEDR, if4.BUSY, {if4.HEX0, if4.HEX1, if4.HEX2, if4.HEX3, if4.HEX4, if4.HEX5});
        return mk(if2.LEDR, if2.BUSY, {if2.HEX0, if2.HEX1, if2.HEX2, if2.HEX3, if2.HEX4, if2.HEX5});
    endfunction

    task automatic check(input string name, input snap_t act, input snap_t exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got ledr=%b busy=%b hex=%h, want ledr=%b busy=%b hex=%h",
                     name, act.ledr, act.busy, act.hex, exp.ledr, exp.busy, exp.hex);
        end
    endtask

    task automatic sb_push(input int at, input int dut, input string name, input snap_t exp);
        sb_q.push_back('{at, dut, name, exp});
    endtask

    // One rising edge, then compare everything due at that edge.
    task automatic step();
        @(negedge clk);
        ecount++;
        for (int i = sb_q.size() - 1; i >= 0; i--) begin
            if (sb_q[i].at == ecount) begin
                check(sb_q[i].name, snap(sb_q[i].dut), sb_q[i].exp);
                sb_q.delete(i);
            end
        end
    endtask

    task automatic drain();
        int budget;
        budget = 64;
        while (sb_q.size() != 0 && budget > 0) begin
            step();
            budget--;
        end
        if (sb_q.size() != 0) begin
            foreach (sb_q[i]) begin
                n_checks++;
                $display("FAIL %s: edge %0d never reached, now at edge %0d", sb_q[i].name, sb_q[i].at, ecount);
            end
            sb_q.delete();
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("%0d/%0d checks passed", n_pass, n_checks + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t  refresh_tbl[$];
        vec_t  row;
        snap_t cur;
        snap_t cur2;
        int    e0;
        int    order[6];
        logic [0:47] h;

        // Reset/refresh table: rel 0 is the last edge with RESET high.
        for (int k = -2; k <= 6; k++) begin
            h = ALL_BLANK;
            for (int j = 0; j < k; j++) h[j*8 +: 8] = H0;
            row.rel = k;
            row.exp = mk(6'b000000, (k < 6), h);
            refresh_tbl.push_back(row);
        end

        if4.SW = '0;
        if2.SW = '0;
        rst4   = 1'b1;
        rst2   = 1'b1;

        // Power-up reset, three clocks, then the six-edge refresh on both.
        e0 = 3;
        foreach (refresh_tbl[i]) begin
            sb_push(e0 + refresh_tbl[i].rel, 4, $sformatf("refresh4_e%0d", refresh_tbl[i].rel), refresh_tbl[i].exp);
            sb_push(e0 + refresh_tbl[i].rel, 2, $sformatf("refresh2_e%0d", refresh_tbl[i].rel), refresh_tbl[i].exp);
        end
        repeat (3) step();
        rst4 = 1'b0;
        rst2 = 1'b0;
        drain();

        // Single switch on channel 2, uncontended.
        cur = mk(6'b000000, 1'b0, ALL_ZERO);
        e0  = ecount + 1;
        if4.SW = 6'b001000;
        sb_push(e0 + 4, 4, "single_pre", cur);
        cur.ledr = 6'b001000; cur.busy = 1'b1;
        sb_push(e0 + 5, 4, "single_ledr", cur);
        cur = with_hex(cur, 2, H1); cur.busy = 1'b0;
        sb_push(e0 + 6, 4, "single_hex", cur);
        drain();

        // Bounce on channel 4: high 3, low 1, high.
        e0 = ecount + 1;
        if4.SW = 6'b001010;
        sb_push(e0 + 5, 4, "bounce_reject", cur);
        sb_push(e0 + 8, 4, "bounce_pre", cur);
        cur.ledr = 6'b001010; cur.busy = 1'b1;
        sb_push(e0 + 9, 4, "bounce_ledr", cur);
        cur = with_hex(cur, 4, H1); cur.busy = 1'b0;
        sb_push(e0 + 10, 4, "bounce_hex", cur);
        sb_push(e0 + 14, 4, "bounce_once", cur);
        repeat (3) step();
        if4.SW = 6'b001000;
        step();
        if4.SW = 6'b001010;
        drain();

        // Channels 2 and 3 flip together: 2 then 3, leaves last = 3.
        e0 = ecount + 1;
        if4.SW = 6'b000110;
        cur.ledr = 6'b000110; cur.busy = 1'b1;
        sb_push(e0 + 5, 4, "pair_a_flip", cur);
        cur = with_hex(cur, 2, H0);
        sb_push(e0 + 6, 4, "pair_a_g2", cur);
        cur = with_hex(cur, 3, H1); cur.busy = 1'b0;
        sb_push(e0 + 7, 4, "pair_a_g3", cur);
        drain();

        // Channels 3 and 4 flip together: 4 first, then wrap round to 3.
        e0 = ecount + 1;
        if4.SW = 6'b000000;
        cur.ledr = 6'b000000; cur.busy = 1'b1;
        sb_push(e0 + 5, 4, "pair_b_flip", cur);
        cur = with_hex(cur, 4, H0);
        sb_push(e0 + 6, 4, "pair_b_g4", cur);
        cur = with_hex(cur, 3, H0); cur.busy = 1'b0;
        sb_push(e0 + 7, 4, "pair_b_g3", cur);
        drain();

        // All six flip on one edge with last = 3: grants 4,5,0,1,2,3.
        order = '{4, 5, 0, 1, 2, 3};
        e0 = ecount + 1;
        if4.SW = 6'b111111;
        cur.ledr = 6'b111111; cur.busy = 1'b1;
        sb_push(e0 + 5, 4, "all_flip", cur);
        for (int i = 0; i < 6; i++) begin
            cur = with_hex(cur, order[i], H1);
            cur.busy = (i < 5);
            sb_push(e0 + 6 + i, 4, $sformatf("all_grant%0d_ch%0d", i, order[i]), cur);
        end
        drain();

        // Mid-operation reset with three channels pending.
        e0 = ecount + 1;
        if4.SW = 6'b000111;
        sb_push(e0 + 5, 4, "midrst_pending", mk(6'b000111, 1'b1, ALL_ONE));
        repeat (6) step();
        rst4   = 1'b1;
        if4.SW = 6'b000000;
        e0 = ecount + 1;
        foreach (refresh_tbl[i]) begin
            if (refresh_tbl[i].rel >= 0)
                sb_push(e0 + refresh_tbl[i].rel, 4, $sformatf("midrst_e%0d", refresh_tbl[i].rel), refresh_tbl[i].exp);
        end
        step();
        rst4 = 1'b0;
        drain();

        // Debounce-2 instance: move last to 3 via channel 3.
        cur2 = mk(6'b000000, 1'b0, ALL_ZERO);
        e0 = ecount + 1;
        if2.SW = 6'b000100;
        cur2.ledr = 6'b000100; cur2.busy = 1'b1;
        sb_push(e0 + 3, 2, "d2_ch3_flip", cur2);
        cur2 = with_hex(cur2, 3, H1); cur2.busy = 1'b0;
        sb_push(e0 + 4, 2, "d2_ch3_hex", cur2);
        drain();

        // Set-wins: channel 0 re-flips on the edge it is granted (5 is ahead).
        e0 = ecount + 1;
        if2.SW = 6'b100101;
        sb_push(e0 + 2, 2, "collide_pre", cur2);
        cur2.ledr = 6'b100101; cur2.busy = 1'b1;
        sb_push(e0 + 3, 2, "collide_flip", cur2);
        cur2 = with_hex(cur2, 5, H1);
        sb_push(e0 + 4, 2, "collide_g5", cur2);
        cur2 = with_hex(cur2, 0, H1); cur2.ledr = 6'b000101;
        sb_push(e0 + 5, 2, "collide_setwins", cur2);
        cur2 = with_hex(cur2, 0, H0); cur2.busy = 1'b0;
        sb_push(e0 + 6, 2, "collide_rewrite", cur2);
        repeat (2) step();
        if2.SW = 6'b000101;
        drain();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
